// File: rtl/mac_pkg.sv
// Shared constants and helpers for the MAC column: instruction bit positions
// and a width-parametrised saturating signed add.
package mac_pkg;

  localparam int INST_LOAD = 0;
  localparam int INST_EXEC = 1;
  localparam int INST_ACC  = 2;
  localparam int INST_LAST = 3;

  localparam int SAT_W = 64;

  // Adds two sign-extended operands and clamps the result to the signed range
  // of a w-bit value (w <= SAT_W). Callers truncate the return value to w bits.
  function automatic logic signed [SAT_W-1:0] sat_add(
    input logic signed [SAT_W-1:0] a,
    input logic signed [SAT_W-1:0] b,
    input int unsigned             w
  );
    logic signed [SAT_W:0] s;
    logic signed [SAT_W:0] hi;
    logic signed [SAT_W:0] lo;
    s  = (SAT_W+1)'(a) + (SAT_W+1)'(b);
    hi = ((SAT_W+1)'(1) <<< (w - 1)) - (SAT_W+1)'(1);
    lo = -hi - (SAT_W+1)'(1);
    if (s > hi)      s = hi;
    else if (s < lo) s = lo;
    return $signed(s[SAT_W-1:0]);
  endfunction

endpackage

// File: rtl/mac_dot.sv
// Combinational pr-lane signed dot product; lane i occupies bits [i*bw +: bw].
module mac_dot #(
  parameter int bw      = 8,
  parameter int bw_psum = 2*bw+4,
  parameter int pr      = 8
) (
  input  logic [pr*bw-1:0]         a,
  input  logic [pr*bw-1:0]         b,
  output logic signed [bw_psum-1:0] psum
);

  logic signed [bw-1:0]   a_lane;
  logic signed [bw-1:0]   b_lane;
  logic signed [2*bw-1:0] prod;

  always_comb begin
    // NOTE: every variable gets a value before the loop, so no path holds an old value (no latch).
    psum   = '0;
    a_lane = '0;
    b_lane = '0;
    prod   = '0;
    for (int i = 0; i < pr; i++) begin
      a_lane = a[i*bw +: bw];
      b_lane = b[i*bw +: bw];
      prod   = (2*bw)'(a_lane) * (2*bw)'(b_lane);
      psum   = psum + bw_psum'(prod);
    end
  end

endmodule

// File: rtl/mac_col_acc.sv
// Systolic MAC column: forwards the query stream, captures nk stationary keys
// from the load stream, and emits direct or saturating-accumulated dot products.
module mac_col_acc
  import mac_pkg::*;
#(
  parameter int bw      = 8,
  parameter int pr      = 8,
  parameter int bw_psum = 2*bw+4,
  parameter int bw_acc  = bw_psum+4,
  parameter int nk      = 2,
  parameter int bw_ks   = (nk > 1) ? $clog2(nk) : 1,
  parameter int lo      = 9,
  parameter int col_id  = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [3:0]               i_inst,
  input  logic [bw_ks-1:0]         i_ksel,
  input  logic [pr*bw-1:0]         q_in,
  output logic [pr*bw-1:0]         q_out,
  output logic [3:0]               o_inst,
  output logic [bw_ks-1:0]         o_ksel,
  output logic signed [bw_acc-1:0] out,
  output logic                     fifo_wr
);

  // Capture point: column c grabs every (cp+1)-th load so downstream columns
  // see keys that arrive later in the forwarded stream.
  localparam int cp     = lo - col_id;
  localparam int bw_cnt = (cp > 0) ? $clog2(cp + 1) : 1;
  localparam logic [bw_cnt-1:0] cp_cnt    = bw_cnt'(cp);
  localparam logic [bw_ks-1:0]  last_slot = bw_ks'(nk - 1);

  logic [3:0]               inst_q, inst_2q;
  logic [bw_ks-1:0]         ksel_q, ksel_2q;
  logic [pr*bw-1:0]         query_q;
  logic [pr*bw-1:0]         key_q [nk];
  logic [bw_cnt-1:0]        cnt_q;
  logic [bw_ks-1:0]         kidx_q;
  logic                     load_ready_q;
  logic signed [bw_acc-1:0] acc_q;
  logic                     acc_act_q;

  logic [pr*bw-1:0]         key_sel;
  logic signed [bw_psum-1:0] psum;
  logic signed [bw_acc-1:0] psum_ext;
  logic signed [bw_acc-1:0] acc_base;
  logic signed [bw_acc-1:0] sum;
  logic                     exec_2q;
  logic                     load_hit;

  assign q_out  = query_q;
  assign o_inst = inst_q;
  assign o_ksel = ksel_q;

  always_comb begin
    key_sel = '0;
    for (int k = 0; k < nk; k++) begin
      if (ksel_2q == bw_ks'(k)) key_sel = key_q[k];
    end
  end

  mac_dot #(.bw(bw), .bw_psum(bw_psum), .pr(pr)) u_dot (
    .a    (query_q),
    .b    (key_sel),
    .psum (psum)
  );

  // A load bit in the same instruction suppresses execute entirely.
  assign exec_2q  = inst_2q[INST_EXEC] && !inst_2q[INST_LOAD];
  assign load_hit = inst_q[INST_LOAD] && load_ready_q;
  assign psum_ext = bw_acc'(psum);
  assign acc_base = acc_act_q ? acc_q : '0;
  assign sum      = bw_acc'(sat_add(SAT_W'(acc_base), SAT_W'(psum_ext), bw_acc));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inst_q       <= '0;
      inst_2q      <= '0;
      ksel_q       <= '0;
      ksel_2q      <= '0;
      query_q      <= '0;
      // NOTE: the key bank is a register array, so it is cleared here like any flop; stale keys must not survive reset.
      for (int k = 0; k < nk; k++) key_q[k] <= '0;
      cnt_q        <= '0;
      kidx_q       <= '0;
      load_ready_q <= 1'b1;
      acc_q        <= '0;
      acc_act_q    <= 1'b0;
      out          <= '0;
      fifo_wr      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register sees pre-edge values.
      inst_q  <= i_inst;
      ksel_q  <= i_ksel;
      inst_2q <= inst_q;
      ksel_2q <= ksel_q;
      if (inst_q[INST_LOAD] || inst_q[INST_EXEC]) query_q <= q_in;

      if (load_hit) begin
        if (cnt_q == cp_cnt) begin
          key_q[kidx_q] <= q_in;
          cnt_q         <= '0;
          kidx_q        <= kidx_q + 1'b1;
          if (kidx_q == last_slot) load_ready_q <= 1'b0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end

      fifo_wr <= 1'b0;
      if (exec_2q) begin
        if (!inst_2q[INST_ACC]) begin
          out       <= psum_ext;
          fifo_wr   <= 1'b1;
          acc_act_q <= 1'b0;
        end else if (inst_2q[INST_LAST]) begin
          out       <= sum;
          fifo_wr   <= 1'b1;
          acc_act_q <= 1'b0;
        end else begin
          acc_q     <= sum;
          acc_act_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_col_acc.sv
// Self-checking bench for mac_col_acc: hand sequences, a table of direct
// executes, and a randomized run against an issue-order reference model.
module tb_mac_col_acc;

  localparam int BW     = 8;
  localparam int PR     = 8;
  localparam int NK     = 2;
  localparam int LO     = 9;
  localparam int COL    = 0;
  localparam int CP     = LO - COL;
  localparam int BW_ACC = 2*BW + 8;
  localparam int BW_KS  = 1;
  localparam int VW     = PR*BW;

  localparam logic [3:0] OP_IDLE = 4'b0000;
  localparam logic [3:0] OP_LOAD = 4'b0001;
  localparam logic [3:0] OP_EXEC = 4'b0010;
  localparam logic [3:0] OP_LDEX = 4'b0011;
  localparam logic [3:0] OP_ACC  = 4'b0110;
  localparam logic [3:0] OP_LAST = 4'b1110;

  localparam longint ACC_MAX = (longint'(1) <<< (BW_ACC-1)) - 1;
  localparam longint ACC_MIN = -ACC_MAX - 1;

  logic                     clk = 1'b0;
  logic                     reset = 1'b0;
  logic [3:0]               i_inst = '0;
  logic [BW_KS-1:0]         i_ksel = '0;
  logic [VW-1:0]            q_in = '0;
  logic [VW-1:0]            q_out;
  logic [3:0]               o_inst;
  logic [BW_KS-1:0]         o_ksel;
  logic signed [BW_ACC-1:0] out;
  logic                     fifo_wr;

  mac_col_acc #(.bw(BW), .pr(PR), .nk(NK), .lo(LO), .col_id(COL)) dut (
    .clk     (clk),
    .reset   (reset),
    .i_inst  (i_inst),
    .i_ksel  (i_ksel),
    .q_in    (q_in),
    .q_out   (q_out),
    .o_inst  (o_inst),
    .o_ksel  (o_ksel),
    .out     (out),
    .fifo_wr (fifo_wr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [VW-1:0] prev_vec = '0;

  // Reference model state, updated in instruction issue order.
  logic [VW-1:0] m_key [NK];
  int            m_load_cnt;
  longint        m_acc;
  bit            m_act;
  longint        exp_val [int];

  typedef struct {
    logic [BW_KS-1:0] ksel;
    int               qv;
    longint           exp;
  } dir_vec_t;
  dir_vec_t tbl [6];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [VW-1:0] splat(input int v);
    logic [VW-1:0] r;
    r = '0;
    for (int i = 0; i < PR; i++) r[i*BW +: BW] = v[BW-1:0];
    return r;
  endfunction

  function automatic longint dot(input logic [VW-1:0] a, input logic [VW-1:0] b);
    longint s;
    byte    ai, bi;
    s = 0;
    for (int i = 0; i < PR; i++) begin
      ai = a[i*BW +: BW];
      bi = b[i*BW +: BW];
      s += longint'(ai) * longint'(bi);
    end
    return s;
  endfunction

  function automatic longint clamp(input longint v);
    if (v > ACC_MAX) return ACC_MAX;
    if (v < ACC_MIN) return ACC_MIN;
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NK; k++) m_key[k] = '0;
    m_load_cnt = 0;
    m_acc = 0;
    m_act = 0;
    exp_val.delete();
  endtask

  // Applies one instruction's effect; results appear three cycles later.
  task automatic model_issue(input logic [3:0] inst, input logic [BW_KS-1:0] ksel,
                             input logic [VW-1:0] vec, input int at);
    longint p, s;
    if (inst[0]) begin
      if (m_load_cnt < NK*(CP+1)) begin
        if (m_load_cnt % (CP+1) == CP) m_key[m_load_cnt/(CP+1)] = vec;
        m_load_cnt++;
      end
    end else if (inst[1]) begin
      p = dot(vec, m_key[ksel]);
      if (!inst[2]) begin
        exp_val[at] = p;
        m_act = 0;
      end else begin
        s = clamp((m_act ? m_acc : 0) + p);
        if (inst[3]) begin
          exp_val[at] = s;
          m_act = 0;
        end else begin
          m_acc = s;
          m_act = 1;
        end
      end
    end
  endtask

  // One clock: instruction now, its vector on q_in one cycle later.
  task automatic drive(input logic [3:0] inst, input logic [BW_KS-1:0] ksel,
                       input logic [VW-1:0] vec);
    i_inst   = inst;
    i_ksel   = ksel;
    q_in     = prev_vec;
    prev_vec = vec;
    model_issue(inst, ksel, vec, cyc + 3);
    @(posedge clk);
    #1;
    cyc++;
    check("o_inst", o_inst, inst);
    check("o_ksel", o_ksel, ksel);
    if (exp_val.exists(cyc)) begin
      check("fifo_wr_hi", fifo_wr, 1);
      check("out", out, exp_val[cyc]);
      exp_val.delete(cyc);
    end else begin
      check("fifo_wr_lo", fifo_wr, 0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(OP_IDLE, '0, '0);
  endtask

  // Asserts reset between edges and checks outputs clear with no clock edge.
  task automatic apply_reset();
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check("rst_out", out, 0);
    check("rst_fifo_wr", fifo_wr, 0);
    check("rst_q_out", q_out, 0);
    check("rst_o_inst", o_inst, 0);
    i_inst = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    prev_vec = '0;
  endtask

  task automatic load_keys(input int v);
    for (int i = 0; i < NK*(CP+1); i++) drive(OP_LOAD, '0, splat(v));
  endtask

  initial begin
    tbl[0] = '{1'b0,    1,     72};
    tbl[1] = '{1'b1,    1,    152};
    tbl[2] = '{1'b0,   -1,    -72};
    tbl[3] = '{1'b1,    3,    456};
    tbl[4] = '{1'b1, -128, -19456};
    tbl[5] = '{1'b0,  127,   9144};

    // Reset held with random inputs.
    model_reset();
    for (int i = 0; i < 4; i++) begin
      i_inst = 4'($urandom);
      i_ksel = BW_KS'($urandom);
      q_in   = {$urandom, $urandom};
      @(posedge clk);
      #1;
      check("hold_out", out, 0);
      check("hold_fifo_wr", fifo_wr, 0);
      check("hold_q_out", q_out, 0);
      check("hold_o_inst", o_inst, 0);
      check("hold_o_ksel", o_ksel, 0);
    end
    @(negedge clk);
    reset = 1'b1;
    idle(3);

    // Key capture: lanes = load index; 21st load (50) must not disturb keys.
    for (int i = 0; i <= NK*(CP+1); i++) begin
      drive(OP_LOAD, '0, splat(i < NK*(CP+1) ? i : 50));
      if (i > 0) check("q_out_track", q_out, splat(i - 1));
    end
    drive(OP_IDLE, '0, '0);
    check("q_out_track_last", q_out, splat(50));
    for (int i = 0; i < 6; i++) begin
      drive(OP_EXEC, tbl[i].ksel, splat(tbl[i].qv));
      idle(3);
      check("tbl_out", out, tbl[i].exp);
    end

    // Direct execute and load+exec suppression with keys = 2.
    apply_reset();
    load_keys(2);
    drive(OP_EXEC, 1'b0, splat(1));
    idle(3);
    check("direct_out", out, 16);
    drive(OP_LDEX, 1'b0, splat(1));
    idle(4);
    check("ldex_out_hold", out, 16);

    // Accumulate, with and without idle gaps, then a direct execute.
    for (int i = 0; i < 3; i++) drive(OP_ACC, 1'b0, splat(1));
    drive(OP_LAST, 1'b0, splat(1));
    idle(3);
    check("acc4_out", out, 64);
    drive(OP_ACC, 1'b0, splat(1));
    drive(OP_ACC, 1'b0, splat(1));
    idle(2);
    drive(OP_ACC, 1'b0, splat(1));
    drive(OP_LAST, 1'b0, splat(1));
    idle(3);
    check("acc_gap_out", out, 64);
    drive(OP_EXEC, 1'b0, splat(1));
    idle(3);
    check("direct_after_acc", out, 16);

    // Async reset mid-accumulation; keys cleared so the next product is 0.
    drive(OP_ACC, 1'b0, splat(1));
    drive(OP_ACC, 1'b0, splat(1));
    apply_reset();
    drive(OP_LAST, 1'b0, splat(1));
    idle(3);
    check("post_reset_out", out, 0);

    // Positive saturation, then per-step clamp on the negative side.
    apply_reset();
    load_keys(-128);
    for (int i = 0; i < 63; i++) drive(OP_ACC, 1'b0, splat(-128));
    drive(OP_LAST, 1'b0, splat(-128));
    idle(3);
    check("sat_pos", out, 8388607);
    for (int i = 0; i < 70; i++) drive(OP_ACC, 1'b1, splat(127));
    drive(OP_LAST, 1'b1, splat(-128));
    idle(3);
    check("sat_neg_recover", out, -8257536);

    // Randomized mix against the model, with one async reset midway.
    apply_reset();
    for (int n = 0; n < 600; n++) begin
      logic [3:0] op;
      int r;
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3: op = OP_LOAD;
        4:          op = OP_IDLE;
        5:          op = OP_EXEC;
        6, 7:       op = OP_ACC;
        8:          op = OP_LAST;
        default:    op = 4'($urandom) | 4'b0001;
      endcase
      drive(op, BW_KS'($urandom), {$urandom, $urandom});
      if (n == 300) apply_reset();
    end
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
